// File: rtl/actuator_pkg.sv
// actuator_pkg: shared state and alarm-cause encodings for the actuator controllers
package actuator_pkg;
   typedef enum logic [2:0] {
      INIT    = 3'd0,
      READY   = 3'd1,
      RELEASE = 3'd2,
      INSERT  = 3'd3,
      STOP    = 3'd4,
      ALARM   = 3'd5
   } state_t;
   typedef enum logic [1:0] {
      CAUSE_NONE    = 2'd0,
      CAUSE_FAULT   = 2'd1,
      CAUSE_TIMEOUT = 2'd2
   } cause_t;
endpackage

// File: rtl/actuator_ch_fsm.sv
// actuator_ch_fsm: one actuator channel with motion timeout, settle delay and latched alarm cause
module actuator_ch_fsm
   import actuator_pkg::*;
#(
   parameter int TMO_W         = 8,
   parameter int MOVE_TIMEOUT  = 100,
   parameter int SETTLE_CYCLES = 4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       en,
   input  logic       direction,
   input  logic       start,
   input  logic       done,
   input  logic       fault,
   input  logic       alarm_ack,
   output logic       en_release,
   output logic       en_insert,
   output logic       en_reset,
   output logic       en_alarm,
   output logic       busy,
   output logic [1:0] alarm_cause
);
   state_t state, state_nx;
   cause_t cause, cause_nx;
   logic [TMO_W-1:0] tmr, tmr_nx;
   logic last;
   assign last = tmr == TMO_W'(1);
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         state <= INIT;
         cause <= CAUSE_NONE;
         tmr   <= '0;
      end else begin
         state <= state_nx;
         cause <= cause_nx;
         tmr   <= tmr_nx;
      end
   // the timer counts down to 1, so the exit lands exactly N edges after entry
   always_comb begin
      state_nx = state;
      cause_nx = cause;
      tmr_nx   = tmr;
      if (state != ALARM && fault) begin
         state_nx = ALARM;
         cause_nx = CAUSE_FAULT;
      end else if (state != ALARM && !en)
         state_nx = INIT;
      else
         case (state)
            INIT:  state_nx = READY;
            READY: if (start) begin
               state_nx = direction ? RELEASE : INSERT;
               tmr_nx   = TMO_W'(MOVE_TIMEOUT);
            end
            RELEASE, INSERT: if (done) begin
               state_nx = STOP;
               tmr_nx   = TMO_W'(SETTLE_CYCLES);
            end else if (last) begin
               state_nx = ALARM;
               cause_nx = CAUSE_TIMEOUT;
            end else
               tmr_nx = tmr - TMO_W'(1);
            STOP: if (last) state_nx = READY;
               else tmr_nx = tmr - TMO_W'(1);
            ALARM: if (alarm_ack && !fault) begin
               state_nx = INIT;
               cause_nx = CAUSE_NONE;
            end
            default: state_nx = INIT;
         endcase
   end
   assign en_release  = state == RELEASE;
   assign en_insert   = state == INSERT;
   assign en_reset    = state == INIT;
   assign en_alarm    = state == ALARM;
   assign busy        = state == RELEASE || state == INSERT || state == STOP;
   assign alarm_cause = cause;
endmodule

// File: rtl/actuator_ctrl_multi.sv
// actuator_ctrl_multi: NCH independent insert/release actuator channels with a combined alarm flag
module actuator_ctrl_multi
   import actuator_pkg::*;
#(
   parameter int NCH           = 4,
   parameter int TMO_W         = 8,
   parameter int MOVE_TIMEOUT  = 100,
   parameter int SETTLE_CYCLES = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [NCH-1:0]   en,
   input  logic [NCH-1:0]   direction,
   input  logic [NCH-1:0]   start,
   input  logic [NCH-1:0]   done,
   input  logic [NCH-1:0]   fault,
   input  logic [NCH-1:0]   alarm_ack,
   output logic [NCH-1:0]   en_release,
   output logic [NCH-1:0]   en_insert,
   output logic [NCH-1:0]   en_reset,
   output logic [NCH-1:0]   en_alarm,
   output logic [NCH-1:0]   busy,
   output logic [2*NCH-1:0] alarm_cause,
   output logic             alarm_any
);
   for (genvar i = 0; i < NCH; i++) begin : g_ch
      actuator_ch_fsm #(
         .TMO_W(TMO_W),
         .MOVE_TIMEOUT(MOVE_TIMEOUT),
         .SETTLE_CYCLES(SETTLE_CYCLES)
      ) u_ch (
         .clk(clk),
         .rst(rst),
         .en(en[i]),
         .direction(direction[i]),
         .start(start[i]),
         .done(done[i]),
         .fault(fault[i]),
         .alarm_ack(alarm_ack[i]),
         .en_release(en_release[i]),
         .en_insert(en_insert[i]),
         .en_reset(en_reset[i]),
         .en_alarm(en_alarm[i]),
         .busy(busy[i]),
         .alarm_cause(alarm_cause[2*i+:2])
      );
   end
   assign alarm_any = |en_alarm;
endmodule

// File: tb/tb_actuator_ctrl_multi.sv
// tb_actuator_ctrl_multi: directed vectors with hand-computed expectations for actuator_ctrl_multi
module tb_actuator_ctrl_multi;
   logic       clk = 0;
   logic       rst = 1;
   logic [3:0] en = 0, direction = 0, start = 0, done = 0, fault = 0, alarm_ack = 0;
   logic [3:0] en_release, en_insert, en_reset, en_alarm, busy;
   logic [7:0] alarm_cause;
   logic       alarm_any;
   int checks = 0, errors = 0;

   actuator_ctrl_multi dut (
      .clk(clk), .rst(rst), .en(en), .direction(direction), .start(start),
      .done(done), .fault(fault), .alarm_ack(alarm_ack),
      .en_release(en_release), .en_insert(en_insert), .en_reset(en_reset),
      .en_alarm(en_alarm), .busy(busy), .alarm_cause(alarm_cause), .alarm_any(alarm_any)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic outs(input string tag, input logic [3:0] rl, ins, rs, al, bz,
                       input logic [7:0] cs, input logic any);
      check({tag, ".en_release"}, 32'(en_release), 32'(rl));
      check({tag, ".en_insert"}, 32'(en_insert), 32'(ins));
      check({tag, ".en_reset"}, 32'(en_reset), 32'(rs));
      check({tag, ".en_alarm"}, 32'(en_alarm), 32'(al));
      check({tag, ".busy"}, 32'(busy), 32'(bz));
      check({tag, ".alarm_cause"}, 32'(alarm_cause), 32'(cs));
      check({tag, ".alarm_any"}, 32'(alarm_any), 32'(any));
   endtask

   initial begin
      repeat (2) step();
      outs("in_reset", 4'h0, 4'h0, 4'hF, 4'h0, 4'h0, 8'h00, 1'b0);
      rst = 0;
      step();
      outs("after_reset", 4'h0, 4'h0, 4'hF, 4'h0, 4'h0, 8'h00, 1'b0);
      en = 4'h1;
      step();
      outs("ch0_ready", 4'h0, 4'h0, 4'hE, 4'h0, 4'h0, 8'h00, 1'b0);

      // release on ch0, done on the 10th cycle of motion, then 4 settle cycles
      start = 4'h1; direction = 4'h1;
      step();
      outs("rel_enter", 4'h1, 4'h0, 4'hE, 4'h0, 4'h1, 8'h00, 1'b0);
      start = 0;
      repeat (9) step();
      check("rel_hold", 32'(en_release), 32'h1);
      done = 4'h1;
      step();
      outs("rel_stop", 4'h0, 4'h0, 4'hE, 4'h0, 4'h1, 8'h00, 1'b0);
      done = 0; start = 4'h1;
      step();
      check("stop_start_ign_rel", 32'(en_release), 32'h0);
      check("stop_busy1", 32'(busy), 32'h1);
      start = 0;
      repeat (2) step();
      check("stop_busy3", 32'(busy), 32'h1);
      step();
      outs("stop_ready", 4'h0, 4'h0, 4'hE, 4'h0, 4'h0, 8'h00, 1'b0);

      // asynchronous reset in the middle of a release
      start = 4'h1; direction = 4'h1;
      step();
      start = 0;
      check("rel2_enter", 32'(en_release), 32'h1);
      #3 rst = 1;
      #1;
      outs("async_rst", 4'h0, 4'h0, 4'hF, 4'h0, 4'h0, 8'h00, 1'b0);
      #2 rst = 0;
      step();
      outs("rst_ready", 4'h0, 4'h0, 4'hE, 4'h0, 4'h0, 8'h00, 1'b0);

      // ch1 insert with no done: timeout after exactly 100 edges
      en = 4'h3;
      step();
      check("ch1_ready", 32'(en_reset), 32'hC);
      start = 4'h2; direction = 4'h0;
      step();
      start = 0;
      check("ins_enter", 32'(en_insert), 32'h2);
      repeat (99) step();
      check("tmo_edge99_ins", 32'(en_insert), 32'h2);
      check("tmo_edge99_alm", 32'(en_alarm), 32'h0);
      step();
      outs("tmo_alarm", 4'h0, 4'h0, 4'hC, 4'h2, 4'h0, 8'h08, 1'b1);
      fault = 4'h2;
      step();
      check("tmo_cause_kept", 32'(alarm_cause), 32'h08);
      fault = 0; alarm_ack = 4'h2;
      step();
      outs("tmo_ack", 4'h0, 4'h0, 4'hE, 4'h0, 4'h0, 8'h00, 1'b0);
      alarm_ack = 0;

      // ch2: fault and done together while inserting, ack gated by fault
      en = 4'h7;
      step();
      check("ch2_ready", 32'(en_reset), 32'h8);
      start = 4'h4; direction = 4'h0;
      step();
      start = 0;
      check("ch2_ins", 32'(en_insert), 32'h4);
      fault = 4'h4; done = 4'h4;
      step();
      outs("fault_wins", 4'h0, 4'h0, 4'h8, 4'h4, 4'h0, 8'h10, 1'b1);
      done = 0; alarm_ack = 4'h4;
      step();
      check("ack_with_fault", 32'(en_alarm), 32'h4);
      fault = 0;
      step();
      outs("ack_clear", 4'h0, 4'h0, 4'hC, 4'h0, 4'h0, 8'h00, 1'b0);
      alarm_ack = 0;
      step();
      check("ch2_ready2", 32'(en_reset), 32'h8);

      // done on the expiry edge wins, then en drop during STOP
      start = 4'h4; direction = 4'h0;
      step();
      start = 0;
      repeat (99) step();
      done = 4'h4;
      step();
      outs("done_at_expiry", 4'h0, 4'h0, 4'h8, 4'h0, 4'h4, 8'h00, 1'b0);
      done = 0; en = 4'h3;
      step();
      outs("en_drop_stop", 4'h0, 4'h0, 4'hC, 4'h0, 4'h0, 8'h00, 1'b0);

      // simultaneous events on several channels
      en = 4'hF;
      step();
      check("all_ready", 32'(en_reset), 32'h0);
      start = 4'h1; direction = 4'h1; fault = 4'h8;
      step();
      outs("indep_a", 4'h1, 4'h0, 4'h0, 4'h8, 4'h1, 8'h40, 1'b1);
      start = 0; fault = 0; alarm_ack = 4'h8; done = 4'h1;
      step();
      outs("indep_b", 4'h0, 4'h0, 4'h8, 4'h0, 4'h1, 8'h00, 1'b0);
      alarm_ack = 0; done = 0;

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/actuator_ctrl_multi.md
Name: actuator_ctrl_multi

Overview:
- Parametrised N-channel successor to the single-channel insert/release controller.
- Each channel runs an independent registered Moore FSM: reset, ready, release, insert, settle and alarm.
- Adds a motion timeout, a settle delay, latched alarm cause and alarm acknowledge.
- Sits between operator/sequencer inputs and actuator drivers; all inputs are synchronous to clk.

Parameters:
- NCH, 4: number of independent actuator channels (1..16).
- TMO_W, 8: width of the per-channel motion timeout counter.
- MOVE_TIMEOUT, 100: max cycles a release/insert may run without done (1..2^TMO_W-1).
- SETTLE_CYCLES, 4: cycles spent in STOP before returning to READY (1..2^TMO_W-1).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- en  in  NCH  per-channel enable; low forces INIT.
- direction  in  NCH  1 = release, 0 = insert; sampled only on start.
- start  in  NCH  motion request; honoured only in READY.
- done  in  NCH  end-of-travel indication.
- fault  in  NCH  external fault; highest priority.
- alarm_ack  in  NCH  clears ALARM when fault is low.
- en_release  out  NCH  high in RELEASE.
- en_insert  out  NCH  high in INSERT.
- en_reset  out  NCH  high in INIT.
- en_alarm  out  NCH  high in ALARM.
- busy  out  NCH  high in RELEASE, INSERT or STOP.
- alarm_cause  out  2*NCH  per channel: 0 none, 1 fault, 2 timeout.
- alarm_any  out  1  OR of en_alarm.

Behaviour:
- Reset (async, any time, including mid-motion):
  - All channels go to INIT and counters clear.
  - en_reset is all ones; all other outputs are 0, alarm_cause is 0.
  - This holds during reset and after release until the first transition.
- Outputs are registered and decoded from state. An input sampled at edge k is reflected at the outputs immediately after edge k (1-cycle latency).
- States, from the shared encoding: INIT=0, READY=1, RELEASE=2, INSERT=3, STOP=4, ALARM=5. Unused codes recover to INIT.
- Per-channel priority at each edge: fault > en low > state-specific transition.
  - fault=1 in any state other than ALARM: go to ALARM, cause=1.
  - en=0 in any state other than ALARM: go to INIT. ALARM ignores en.
- INIT: en=1 goes to READY.
- READY: start=1 goes to RELEASE if direction=1, else INSERT, and loads the timer with MOVE_TIMEOUT.
- RELEASE/INSERT:
  - done=1 goes to STOP and loads the timer with SETTLE_CYCLES.
  - Otherwise the timer decrements each cycle.
  - If entered at edge k and done is never sampled high, the channel enters ALARM at edge k+MOVE_TIMEOUT with cause=2.
  - done and timer expiry at the same edge: done wins.
  - done and fault at the same edge: fault wins.
  - start and direction changes are ignored.
- STOP: if entered at edge k, returns to READY at edge k+SETTLE_CYCLES. start is ignored during STOP.
- ALARM:
  - Holds until alarm_ack=1 and fault=0 at the same edge, then goes to INIT and clears the cause.
  - alarm_ack while fault=1 has no effect.
  - A new fault does not overwrite a latched timeout cause.
- Channels are fully independent: no shared state except alarm_any. Simultaneous events on different channels are all honoured in the same cycle.
- Exactly one of en_release, en_insert, en_reset, en_alarm is high per channel, except in READY and STOP, where all four are 0.

Decomposition:
- Shared package/include actuator_pkg holds:
  - state encodings INIT..ALARM (3-bit);
  - cause codes CAUSE_NONE/FAULT/TIMEOUT (2-bit).
- Sub-module actuator_ch_fsm: one channel (FSM + TMO_W-bit counter + cause register), taking the same parameters minus NCH.
- Top level instantiates actuator_ch_fsm NCH times with a generate loop, slices the buses, and ORs en_alarm into alarm_any.

Test Plan:
- Reset and enable: rst pulse mid-RELEASE on ch0 -> en_reset=4'hF and all other outputs 0 immediately; en=4'h1, then ch0 READY one edge later with all four enables 0.
- Release motion: ch0 start=1, direction=1 -> en_release[0]=1 after the edge; done at cycle 10 -> STOP; busy stays high 4 more cycles, then READY.
- Timeout: ch1 insert, done never asserted, MOVE_TIMEOUT=100 -> en_alarm[1]=1 exactly 100 edges after entry, alarm_cause[3:2]=2, alarm_any=1; ack -> INIT.
- Fault priority: ch2 in INSERT with fault and done both high at one edge -> ALARM with cause=1; ack while fault=1 -> stays ALARM; ack with fault=0 -> INIT.
- Boundaries: done coinciding with timer expiry -> STOP, not ALARM; en drop during STOP -> INIT next edge; start during STOP ignored.
- Independence: ch0 release, ch3 alarm and ch1 idle stimulated in the same cycles -> each channel matches a per-channel reference model; no cross-channel effect.
